// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the 5-stage RV32 pipeline.
// Optional load-use stall counter is built only when FWD_STALL_CNT_EN is defined.
module fwd_hazard_ctrl #(
    parameter int ADDR_SIZE = 5,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [ADDR_SIZE-1:0] id_rs1_addr,
    input  logic [ADDR_SIZE-1:0] id_rs2_addr,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [ADDR_SIZE-1:0] id_rd_addr,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic                 rs1_exe_hazard,
    output logic                 rs1_mem_hazard,
    output logic                 rs2_exe_hazard,
    output logic                 rs2_mem_hazard,
    output logic                 load_use_stall,
    output logic [CNT_SIZE-1:0]  stall_count
);

    typedef struct packed {
        logic                 valid;
        logic [ADDR_SIZE-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } e_rec_t;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_SIZE-1:0] rd;
        logic                 reg_write;
    } m_rec_t;

    e_rec_t e_q;
    m_rec_t m_q;

    logic [1:0][ADDR_SIZE-1:0] src_addr;
    logic [1:0]                src_used;
    logic [1:0]                e_hit, m_hit, exe_nxt, mem_nxt;
    logic [1:0]                exe_q, mem_q;

    // Index 0 is rs1, index 1 is rs2.
    assign src_addr = {id_rs2_addr, id_rs1_addr};
    assign src_used = {id_rs2_used, id_rs1_used};

    for (genvar s = 0; s < 2; s++) begin : g_src
        assign e_hit[s] = e_q.valid && e_q.reg_write && (e_q.rd == src_addr[s]) &&
                          (src_addr[s] != '0) && src_used[s];
        assign m_hit[s] = m_q.valid && m_q.reg_write && (m_q.rd == src_addr[s]) &&
                          (src_addr[s] != '0) && src_used[s];
        // Youngest producer wins, so exe and mem are never both set.
        assign exe_nxt[s] = e_hit[s];
        assign mem_nxt[s] = m_hit[s] && !e_hit[s];
    end

    assign load_use_stall = id_valid && e_q.valid && e_q.mem_read && (|e_hit) &&
                            !flush && !mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q   <= '0;
            m_q   <= '0;
            exe_q <= '0;
            mem_q <= '0;
        end else if (!mem_stall) begin
            m_q.valid     <= e_q.valid;
            m_q.rd        <= e_q.rd;
            m_q.reg_write <= e_q.reg_write;
            if (flush || load_use_stall) begin
                e_q   <= '0;
                exe_q <= '0;
                mem_q <= '0;
            end else begin
                e_q.valid     <= id_valid;
                e_q.rd        <= id_rd_addr;
                e_q.reg_write <= id_reg_write;
                e_q.mem_read  <= id_mem_read;
                exe_q         <= id_valid ? exe_nxt : 2'b00;
                mem_q         <= id_valid ? mem_nxt : 2'b00;
            end
        end
    end

    assign rs1_exe_hazard = exe_q[0];
    assign rs1_mem_hazard = mem_q[0];
    assign rs2_exe_hazard = exe_q[1];
    assign rs2_mem_hazard = mem_q[1];

`ifdef FWD_STALL_CNT_EN
    logic [CNT_SIZE-1:0] cnt_q;

    // Saturating; load_use_stall is already low whenever mem_stall is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (load_use_stall && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl; hazard vector order is
// {rs1_exe, rs1_mem, rs2_exe, rs2_mem}.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic        flush = 1'b0, mem_stall = 1'b0;
    logic        rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard;
    logic        load_use_stall;
    logic [15:0] stall_count;

    fwd_hazard_ctrl #(.ADDR_SIZE(5), .CNT_SIZE(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .mem_stall(mem_stall),
        .rs1_exe_hazard(rs1_exe_hazard), .rs1_mem_hazard(rs1_mem_hazard),
        .rs2_exe_hazard(rs2_exe_hazard), .rs2_mem_hazard(rs2_mem_hazard),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic [3:0]  haz;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;

    function automatic logic [3:0] haz_now();
        return {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage cycle, check the combinational stall mid-cycle,
    // then check the registered results after the edge.
    task automatic step(input string tag, input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl, input logic ms,
                        input logic es, input logic [3:0] eh);
        exp_t e;
        @(negedge clk);
        id_valid = v; id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2;
        id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
        flush = fl; mem_stall = ms;
`ifdef FWD_STALL_CNT_EN
        if (es && exp_cnt != 16'hffff) exp_cnt++;
`endif
        e.tag = tag; e.stall = es; e.haz = eh; e.cnt = exp_cnt;
        sb.push_back(e);
        #1 chk({tag, "/stall"}, {15'd0, load_use_stall}, {15'd0, sb[0].stall});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "/haz"}, {12'd0, haz_now()}, {12'd0, e.haz});
        chk({e.tag, "/cnt"}, stall_count, e.cnt);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset/haz", {12'd0, haz_now()}, 16'd0);
        chk("reset/stall", {15'd0, load_use_stall}, 16'd0);
        chk("reset/cnt", stall_count, 16'd0);
        @(negedge clk) rst = 1'b0;

        //       tag          v rs1  u rs2  u rd  rw mr fl ms  stall haz
        // back-to-back ALU
        step("add5",        1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 4'b0000);
        step("sub6",        1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0, 4'b1000);
        // distance-2 producer
        step("add5b",       1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 4'b0000);
        step("nop",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("or7",         1, 4, 1, 5, 1, 7, 1, 0, 0, 0, 0, 4'b0001);
        // two producers of x5: youngest wins
        step("add5c",       1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 4'b0000);
        step("add5d",       1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 4'b0000);
        step("cons55",      1, 5, 1, 5, 1, 10, 1, 0, 0, 0, 0, 4'b1010);
        // load-use
        step("lw8",         1, 1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 4'b0000);
        step("add9_stall",  1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 1, 4'b0000);
        step("add9_fwd",    1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 0, 4'b0101);
        // x0, no reg_write, unused source
        step("add_x0",      1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 4'b0000);
        step("rd_x0",       1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("prod_nowr",   1, 1, 1, 2, 1, 12, 0, 0, 0, 0, 0, 4'b0000);
        step("cons_nowr",   1, 12, 1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("prod13",      1, 1, 1, 2, 1, 13, 1, 0, 0, 0, 0, 4'b0000);
        step("cons_unused", 1, 13, 0, 13, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        // load-use squashed by flush: E must be a bubble next cycle
        step("lw8_f",       1, 1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 4'b0000);
        step("add9_flush",  1, 8, 1, 8, 1, 9, 1, 0, 1, 0, 0, 4'b0000);
        step("after_flush", 1, 9, 1, 8, 1, 9, 1, 0, 0, 0, 0, 4'b0001);
        // load-use frozen by mem_stall, stall after release
        step("lw8_m",       1, 9, 1, 0, 0, 8, 1, 1, 0, 0, 0, 4'b1000);
        step("ms1",         1, 8, 1, 8, 1, 9, 1, 0, 0, 1, 0, 4'b1000);
        step("ms2",         1, 8, 1, 8, 1, 9, 1, 0, 0, 1, 0, 4'b1000);
        step("ms3",         1, 8, 1, 8, 1, 9, 1, 0, 0, 1, 0, 4'b1000);
        step("ms_release",  1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 1, 4'b0000);
        step("ms_fwd",      1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 0, 4'b0101);
        // reset asserted in the middle of a stall cycle
        step("lw8_r",       1, 9, 1, 0, 0, 8, 1, 1, 0, 0, 0, 4'b1000);
        @(negedge clk);
        id_valid = 1; id_rs1_addr = 8; id_rs1_used = 1; id_rs2_addr = 8; id_rs2_used = 1;
        id_rd_addr = 9; id_reg_write = 1; id_mem_read = 0; flush = 0; mem_stall = 0;
        #1 chk("pre_rst/stall", {15'd0, load_use_stall}, 16'd1);
        rst = 1'b1;
        exp_cnt = '0;
        #1;
        chk("mid_rst/stall", {15'd0, load_use_stall}, 16'd0);
        chk("mid_rst/haz", {12'd0, haz_now()}, 16'd0);
        chk("mid_rst/cnt", stall_count, 16'd0);
        @(negedge clk) rst = 1'b0;
        step("post_rst",    1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
